// File: rtl/postproc_pipeline_pkg.sv
// Shared definitions for the video post-process pipeline: scanline mode
// codes, the fixed pipeline depth and the power-up shadow configuration.
package postproc_pipeline_pkg;

  typedef enum logic [1:0] {
    SL_MODE_OFF  = 2'd0,
    SL_MODE_H    = 2'd1,
    SL_MODE_V    = 2'd2,
    SL_MODE_GRID = 2'd3
  } sl_mode_e;

  // Every output (colour, syncs, DE) lags its input by this many clocks.
  localparam int PP_LATENCY = 4;

  // Shadow configuration values held until the first frame boundary.
  localparam sl_mode_e   SH_MODE_DEF = SL_MODE_OFF;
  localparam logic [3:0] SH_STR_DEF  = 4'd0;
  localparam logic [3:0] SH_BR_DEF   = 4'd0;

endpackage

// File: rtl/postproc_chan.sv
// One colour channel of the post-process pipeline: fade (S2), scanline
// darkening (S3) and border mask (S4). Control decisions (scanline hit,
// mask) are made in the top and arrive already aligned to each stage.
module postproc_chan
  import postproc_pipeline_pkg::*;
#(
  parameter int IN_BITS   = 4,
  parameter int FADE_BITS = 4,
  parameter int OUT_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_BITS-1:0]   data_p1,
  input  logic [FADE_BITS-1:0] fade_p1,
  input  logic                 fade_byp,
  input  logic [3:0]           str_code,
  input  logic                 hit_p2,
  input  logic                 mask_p3,
  input  logic [3:0]           mask_br,
  output logic [OUT_BITS-1:0]  pix_p4
);

  localparam int PW   = IN_BITS + FADE_BITS + 1;
  localparam int CW   = (PW > OUT_BITS) ? PW : OUT_BITS + 1;
  localparam int SW   = OUT_BITS + 1;
  localparam int REPS = (OUT_BITS + IN_BITS - 1) / IN_BITS;

  // data*(F+2), clipped to full scale.
  function automatic logic [OUT_BITS-1:0] fade_sat(input logic [IN_BITS-1:0] d,
                                                   input logic [FADE_BITS-1:0] f);
    logic [CW-1:0] prod;
    prod = CW'(d) * (CW'(f) + CW'(2));
    if (prod > CW'({OUT_BITS{1'b1}})) return '1;
    return prod[OUT_BITS-1:0];
  endfunction

  // Left-justify by repeating the input pattern so full scale maps to full scale.
  function automatic logic [OUT_BITS-1:0] bit_rep(input logic [IN_BITS-1:0] d);
    logic [REPS*IN_BITS-1:0] t;
    t = {REPS{d}};
    return t[REPS*IN_BITS-1 -: OUT_BITS];
  endfunction

  // Strength code to subtrahend: ((code+1) << (OUT_BITS-4)) - 1.
  function automatic logic [OUT_BITS-1:0] sl_strength(input logic [3:0] c);
    logic [SW-1:0] t;
    t = ((SW'(c) + SW'(1)) << (OUT_BITS - 4)) - SW'(1);
    return t[OUT_BITS-1:0];
  endfunction

  // Darken with floor at zero.
  function automatic logic [OUT_BITS-1:0] sl_darken(input logic [OUT_BITS-1:0] p,
                                                    input logic [OUT_BITS-1:0] s);
    return (p > s) ? (p - s) : '0;
  endfunction

  logic [OUT_BITS-1:0] p_p2_d,   p_p2_q;
  logic [OUT_BITS-1:0] sl_p3_d,  sl_p3_q;
  logic [OUT_BITS-1:0] pix_p4_d, pix_p4_q;

  // Next-state for the three datapath stages.
  always_comb begin
    // S1 -> S2: fade or bypass expansion
    p_p2_d   = fade_byp ? bit_rep(data_p1) : fade_sat(data_p1, fade_p1);
    // S2 -> S3: one scanline subtraction regardless of H/V overlap
    sl_p3_d  = hit_p2 ? sl_darken(p_p2_q, sl_strength(str_code)) : p_p2_q;
    // S3 -> S4: border mask overrides the scanline result
    pix_p4_d = mask_p3 ? {mask_br, {(OUT_BITS-4){1'b0}}} : sl_p3_q;
  end

  // Stage registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_p2_q   <= '0;
      sl_p3_q  <= '0;
      pix_p4_q <= '0;
    end else begin
      p_p2_q   <= p_p2_d;
      sl_p3_q  <= sl_p3_d;
      pix_p4_q <= pix_p4_d;
    end
  end

  assign pix_p4 = pix_p4_q;

endmodule

// File: rtl/postproc_pipeline.sv
// Video post-process pipeline top: input register stage, VSYNC leading-edge
// detect, shadow configuration, frame parity, scanline hit decision and the
// sync/DE delay line. Colour processing lives in three postproc_chan copies.
module postproc_pipeline
  import postproc_pipeline_pkg::*;
#(
  parameter int IN_BITS   = 4,
  parameter int FADE_BITS = 4,
  parameter int OUT_BITS  = 8,
  parameter int ID_BITS   = 3,
  parameter int NUM_IDS   = 8,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic                 PCLK,
  input  logic                 reset,
  input  logic [IN_BITS-1:0]   R_in,
  input  logic [IN_BITS-1:0]   G_in,
  input  logic [IN_BITS-1:0]   B_in,
  input  logic [FADE_BITS-1:0] F_in,
  input  logic                 HSYNC_in,
  input  logic                 VSYNC_in,
  input  logic                 DE_in,
  input  logic [ID_BITS-1:0]   line_id,
  input  logic [ID_BITS-1:0]   col_id,
  input  logic                 mask_enable,
  input  logic [1:0]           cfg_sl_mode,
  input  logic [3:0]           cfg_sl_str,
  input  logic [NUM_IDS-1:0]   cfg_sl_hmask,
  input  logic [NUM_IDS-1:0]   cfg_sl_vmask,
  input  logic                 cfg_alt_en,
  input  logic                 cfg_fade_byp,
  input  logic [3:0]           cfg_mask_br,
  output logic [OUT_BITS-1:0]  R_out,
  output logic [OUT_BITS-1:0]  G_out,
  output logic [OUT_BITS-1:0]  B_out,
  output logic                 HSYNC_out,
  output logic                 VSYNC_out,
  output logic                 DE_out,
  output logic                 frame_odd,
  output logic                 cfg_applied
);

  localparam logic       SYNC_IDLE = ~SYNC_POL;
  localparam logic [2:0] SYNC_RST  = {SYNC_IDLE, SYNC_IDLE, 1'b0};

  // {HSYNC, VSYNC, DE} delay line; entry 0 is the S1 sample.
  logic [2:0] sync_d [PP_LATENCY];
  logic [2:0] sync_q [PP_LATENCY];

  logic [IN_BITS-1:0]   r_p1_d, r_p1_q, g_p1_d, g_p1_q, b_p1_d, b_p1_q;
  logic [FADE_BITS-1:0] f_p1_d, f_p1_q;
  logic [ID_BITS-1:0]   lid_p1_d, lid_p1_q, cid_p1_d, cid_p1_q;
  logic                 mask_p1_d, mask_p1_q, mask_p2_d, mask_p2_q, mask_p3_d, mask_p3_q;
  logic                 hit_p2_d, hit_p2_q;

  sl_mode_e             sh_mode_d, sh_mode_q;
  logic [3:0]           sh_str_d, sh_str_q, sh_br_d, sh_br_q;
  logic [NUM_IDS-1:0]   sh_hmask_d, sh_hmask_q, sh_vmask_d, sh_vmask_q;
  logic                 sh_alt_d, sh_alt_q, sh_byp_d, sh_byp_q;
  logic                 frame_odd_d, frame_odd_q, cfg_applied_d, cfg_applied_q;

  logic                 vs_edge;
  logic [ID_BITS-1:0]   lid_eff;

  // Leading edge: VSYNC active now, inactive on the previous sample.
  assign vs_edge = (VSYNC_in == SYNC_POL) && (sync_q[0][1] != SYNC_POL);

  // Sync/DE delay line and the S1 pixel capture.
  always_comb begin
    sync_d[0] = {HSYNC_in, VSYNC_in, DE_in};
    for (int i = 1; i < PP_LATENCY; i++) sync_d[i] = sync_q[i-1];
    r_p1_d    = R_in;
    g_p1_d    = G_in;
    b_p1_d    = B_in;
    f_p1_d    = F_in;
    lid_p1_d  = line_id;
    cid_p1_d  = col_id;
    mask_p1_d = mask_enable;
  end

  // Shadow config and frame parity update only on the VSYNC leading edge.
  always_comb begin
    sh_mode_d     = sh_mode_q;
    sh_str_d      = sh_str_q;
    sh_hmask_d    = sh_hmask_q;
    sh_vmask_d    = sh_vmask_q;
    sh_alt_d      = sh_alt_q;
    sh_byp_d      = sh_byp_q;
    sh_br_d       = sh_br_q;
    frame_odd_d   = frame_odd_q;
    cfg_applied_d = vs_edge;
    if (vs_edge) begin
      sh_mode_d   = sl_mode_e'(cfg_sl_mode);
      sh_str_d    = cfg_sl_str;
      sh_hmask_d  = cfg_sl_hmask;
      sh_vmask_d  = cfg_sl_vmask;
      sh_alt_d    = cfg_alt_en;
      sh_byp_d    = cfg_fade_byp;
      sh_br_d     = cfg_mask_br;
      frame_odd_d = ~frame_odd_q;
    end
  end

  // Scanline hit decision and mask alignment for the channel stages.
  always_comb begin
    // S1 -> S2: alternate phase flips only the line_id LSB on odd frames
    lid_eff   = lid_p1_q ^ ID_BITS'(frame_odd_q & sh_alt_q);
    hit_p2_d  = (((sh_mode_q == SL_MODE_H) || (sh_mode_q == SL_MODE_GRID)) && sh_hmask_q[lid_eff]) ||
                (((sh_mode_q == SL_MODE_V) || (sh_mode_q == SL_MODE_GRID)) && sh_vmask_q[cid_p1_q]);
    mask_p2_d = mask_p1_q;
    // S2 -> S3
    mask_p3_d = mask_p2_q;
  end

  // All control and pipeline registers, cleared by the asynchronous reset.
  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PP_LATENCY; i++) sync_q[i] <= SYNC_RST;
      r_p1_q        <= '0;
      g_p1_q        <= '0;
      b_p1_q        <= '0;
      f_p1_q        <= '0;
      lid_p1_q      <= '0;
      cid_p1_q      <= '0;
      mask_p1_q     <= 1'b0;
      mask_p2_q     <= 1'b0;
      mask_p3_q     <= 1'b0;
      hit_p2_q      <= 1'b0;
      sh_mode_q     <= SH_MODE_DEF;
      sh_str_q      <= SH_STR_DEF;
      sh_hmask_q    <= '0;
      sh_vmask_q    <= '0;
      sh_alt_q      <= 1'b0;
      sh_byp_q      <= 1'b0;
      sh_br_q       <= SH_BR_DEF;
      frame_odd_q   <= 1'b0;
      cfg_applied_q <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      r_p1_q        <= r_p1_d;
      g_p1_q        <= g_p1_d;
      b_p1_q        <= b_p1_d;
      f_p1_q        <= f_p1_d;
      lid_p1_q      <= lid_p1_d;
      cid_p1_q      <= cid_p1_d;
      mask_p1_q     <= mask_p1_d;
      mask_p2_q     <= mask_p2_d;
      mask_p3_q     <= mask_p3_d;
      hit_p2_q      <= hit_p2_d;
      sh_mode_q     <= sh_mode_d;
      sh_str_q      <= sh_str_d;
      sh_hmask_q    <= sh_hmask_d;
      sh_vmask_q    <= sh_vmask_d;
      sh_alt_q      <= sh_alt_d;
      sh_byp_q      <= sh_byp_d;
      sh_br_q       <= sh_br_d;
      frame_odd_q   <= frame_odd_d;
      cfg_applied_q <= cfg_applied_d;
    end
  end

  postproc_chan #(.IN_BITS(IN_BITS), .FADE_BITS(FADE_BITS), .OUT_BITS(OUT_BITS)) u_chan_r (
    .clk(PCLK), .rst(reset), .data_p1(r_p1_q), .fade_p1(f_p1_q), .fade_byp(sh_byp_q),
    .str_code(sh_str_q), .hit_p2(hit_p2_q), .mask_p3(mask_p3_q), .mask_br(sh_br_q), .pix_p4(R_out)
  );

  postproc_chan #(.IN_BITS(IN_BITS), .FADE_BITS(FADE_BITS), .OUT_BITS(OUT_BITS)) u_chan_g (
    .clk(PCLK), .rst(reset), .data_p1(g_p1_q), .fade_p1(f_p1_q), .fade_byp(sh_byp_q),
    .str_code(sh_str_q), .hit_p2(hit_p2_q), .mask_p3(mask_p3_q), .mask_br(sh_br_q), .pix_p4(G_out)
  );

  postproc_chan #(.IN_BITS(IN_BITS), .FADE_BITS(FADE_BITS), .OUT_BITS(OUT_BITS)) u_chan_b (
    .clk(PCLK), .rst(reset), .data_p1(b_p1_q), .fade_p1(f_p1_q), .fade_byp(sh_byp_q),
    .str_code(sh_str_q), .hit_p2(hit_p2_q), .mask_p3(mask_p3_q), .mask_br(sh_br_q), .pix_p4(B_out)
  );

  assign HSYNC_out   = sync_q[PP_LATENCY-1][2];
  assign VSYNC_out   = sync_q[PP_LATENCY-1][1];
  assign DE_out      = sync_q[PP_LATENCY-1][0];
  assign frame_odd   = frame_odd_q;
  assign cfg_applied = cfg_applied_q;

endmodule
